cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
- Sequencer that generates the CPU's instruction-advance strobe (`cpu_stb`, driving the CPU's `clk_stb_800k` input) from the single system clock.
- Provides free-run, single-step debug, PC breakpoint and halt-freeze modes.
- Sits between the board clock, reset and debug inputs and the cpu core; the cpu core commits exactly one instruction per `cpu_stb` cycle.

Parameters:
- WORD_WIDTH, 16, width of PC and breakpoint address.
- CLK_DIV, 62, system clocks per run-mode strobe period (50 MHz / ~800 kHz); legal range 2..255.
- SYNC_STAGES, 2, flip-flop stages synchronising `debug_clk`.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- debug_mode  in  1  level; 1 = single-step mode.
- debug_clk  in  1  asynchronous step input; each rising edge = one step.
- resume  in  1  one-cycle pulse; leaves BREAK.
- halted  in  1  cpu decode of the HALT opcode at the current PC.
- pc  in  WORD_WIDTH  current cpu PC.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  WORD_WIDTH  breakpoint PC.
- cpu_stb  out  1  registered; high for exactly one clk cycle per instruction.
- state  out  2  RUN=0, STEP=1, BREAK=2, HALT=3.
- bp_hit  out  1  high while state==BREAK.
- instr_count  out  16  number of strobes issued since reset.

Behaviour:
- Reset (rst=1 at posedge) values:
  - state=RUN; divider=0; cpu_stb=0; instr_count=0; skip_bp=0; bp_hit=0.
  - Sync chain and edge-detect previous bit loaded with 1, so a `debug_clk` held high through reset gives no step.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - `tick` = (divider==CLK_DIV-1); runs only in RUN.
  - Forced to 0 in every other state and on entry to RUN.
- cpu_stb is registered: a decision made in cycle N appears in cycle N+1, high for one cycle only.
- Priority each cycle: rst > debug_mode > halted > breakpoint > tick.
- RUN:
  - debug_mode=1 -> STEP; no strobe this cycle.
  - Else halted=1 -> HALT; no strobe.
  - Else tick & bp_en & pc==bp_addr & ~skip_bp -> BREAK; no strobe.
  - Else tick -> strobe; skip_bp cleared.
- STEP:
  - Strobe once per rising edge of the synchronised `debug_clk` (prev=0, cur=1).
  - Latency from first sampling of high to cpu_stb is SYNC_STAGES+1 cycles.
  - Breakpoint and halted are ignored: stepping onto HALT is harmless because the cpu holds its PC.
  - debug_mode=0 -> RUN with divider=0 and skip_bp=1, so the current PC is not re-broken.
  - An edge in the same cycle debug_mode falls is dropped.
- BREAK:
  - No strobes.
  - debug_mode=1 -> STEP.
  - Else resume=1 -> RUN with skip_bp=1; the first tick strobes regardless of the breakpoint.
  - Changing bp_addr or bp_en has no effect until the next RUN tick.
- HALT:
  - No strobes.
  - Exited only by rst; debug_mode, resume and debug_clk are ignored.
- instr_count:
  - +1 in the cycle cpu_stb=1; wraps 16'hFFFF -> 0.
  - Holds in every other cycle.
- Reset mid-operation:
  - Any pending step edge or strobe is discarded.
  - cpu_stb=0 in the cycle after rst is sampled.
- Minimum strobe spacing:
  - RUN: CLK_DIV cycles.
  - STEP: 2 cycles (edge detect requires low-then-high).

Test Plan (CLK_DIV=4 in bench):
- Release rst, all debug inputs 0 -> cpu_stb high on cycles 4, 8, 12 after release (each exactly 1 cycle wide); instr_count = 3 after cycle 12.
- RUN, assert debug_mode, give 3 `debug_clk` pulses, each 5 cycles high and 5 low -> exactly 3 strobes, each 3 cycles after its rising edge; no tick strobes; state=1; instr_count +3.
- bp_en=1, bp_addr=16'h0005, pc driven from a counter that increments on cpu_stb -> strobes stop with pc=5, state=2, bp_hit=1.
  - Pulse resume -> next strobe 4 cycles later and pc advances to 6; no re-break at 5.
- halted=1 while in RUN -> no further strobes, state=3.
  - Toggling debug_mode, resume and debug_clk for 50 cycles -> still state=3, count unchanged.
  - rst -> state=0, count=0.
- Preload instr_count to 16'hFFFE via 65534 strobes (or a forced value) -> next two strobes give 16'hFFFF then 16'h0000.
- Hold debug_clk high across rst, then enter STEP -> no strobe until debug_clk goes low then high again; rst asserted mid-step-pulse -> no strobe issued.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: generates the cpu instruction-advance strobe from the system clock.
// Supports free-run, single-step debug, PC breakpoint and halt-freeze modes.
module cpu_step_ctrl #(
    parameter int WORD_WIDTH  = 16,
    parameter int CLK_DIV     = 62,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  debug_mode,
    input  logic                  debug_clk,
    input  logic                  resume,
    input  logic                  halted,
    input  logic [WORD_WIDTH-1:0] pc,
    input  logic                  bp_en,
    input  logic [WORD_WIDTH-1:0] bp_addr,
    output logic                  cpu_stb,
    output logic [1:0]            state,
    output logic                  bp_hit,
    output logic [15:0]           instr_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STEP  = 2'd1,
        ST_BREAK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t                 cur_state;
    state_t                 nxt_state;
    logic [7:0]             divider;
    logic                   tick;
    logic                   skip_bp;
    logic                   strobe_nxt;
    logic [SYNC_STAGES-1:0] dbg_sync;
    logic                   dbg_cur;
    logic                   dbg_prev;
    logic                   step_edge;
    logic                   bp_match;
    logic                   bp_fire;

    assign tick      = (divider == 8'(CLK_DIV - 1));
    assign step_edge = dbg_cur & ~dbg_prev;
    assign bp_match  = bp_en && (pc == bp_addr);
    assign bp_fire   = tick && bp_match && !skip_bp;
    assign state     = cur_state;

    // debug_clk synchroniser plus edge-detect pair; all ones on reset so a held-high input gives no step.
    // dbg_cur is an extra stage after the chain, giving SYNC_STAGES+1 cycles from sampling to strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_sync <= '1;
            dbg_cur  <= 1'b1;
            dbg_prev <= 1'b1;
        end else begin
            dbg_sync[0] <= debug_clk;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                dbg_sync[i] <= dbg_sync[i-1];
            end
            dbg_cur  <= dbg_sync[SYNC_STAGES-1];
            dbg_prev <= dbg_cur;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic; priority debug_mode > halted > breakpoint > tick.
    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            ST_RUN: begin
                if (debug_mode) begin
                    nxt_state = ST_STEP;
                end else if (halted) begin
                    nxt_state = ST_HALT;
                end else if (bp_fire) begin
                    nxt_state = ST_BREAK;
                end
            end
            ST_STEP: begin
                if (!debug_mode) begin
                    nxt_state = ST_RUN;
                end
            end
            ST_BREAK: begin
                if (debug_mode) begin
                    nxt_state = ST_STEP;
                end else if (resume) begin
                    nxt_state = ST_RUN;
                end
            end
            ST_HALT: begin
                nxt_state = ST_HALT;
            end
            default: begin
                nxt_state = ST_RUN;
            end
        endcase
    end

    // Output decode: strobe request for the next cycle and breakpoint flag.
    always_comb begin
        strobe_nxt = 1'b0;
        bp_hit     = 1'b0;
        unique case (cur_state)
            ST_RUN:   strobe_nxt = !debug_mode && !halted && tick && !bp_fire;
            ST_STEP:  strobe_nxt = debug_mode && step_edge;
            ST_BREAK: bp_hit     = 1'b1;
            ST_HALT:  strobe_nxt = 1'b0;
            default:  strobe_nxt = 1'b0;
        endcase
    end

    // Run-mode divider; held at zero outside RUN and cleared on any RUN exit so re-entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            divider <= '0;
        end else if (cur_state == ST_RUN && nxt_state == ST_RUN) begin
            divider <= tick ? '0 : divider + 8'd1;
        end else begin
            divider <= '0;
        end
    end

    // Breakpoint skip flag: set on return to RUN so the current PC is not re-broken, cleared by a run strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_bp <= 1'b0;
        end else if (cur_state == ST_RUN && strobe_nxt) begin
            skip_bp <= 1'b0;
        end else if (cur_state != ST_RUN && nxt_state == ST_RUN) begin
            skip_bp <= 1'b1;
        end
    end

    // Registered strobe and instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_stb     <= 1'b0;
            instr_count <= '0;
        end else begin
            cpu_stb <= strobe_nxt;
            if (cpu_stb) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench for cpu_step_ctrl with CLK_DIV=4.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        debug_mode = 1'b0;
    logic        debug_clk = 1'b0;
    logic        resume = 1'b0;
    logic        halted = 1'b0;
    logic [15:0] pc;
    logic        bp_en = 1'b0;
    logic [15:0] bp_addr = '0;
    logic        cpu_stb;
    logic [1:0]  state;
    logic        bp_hit;
    logic [15:0] instr_count;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_cnt = '0;
    int unsigned r;
    int unsigned s;

    cpu_step_ctrl #(
        .WORD_WIDTH (16),
        .CLK_DIV    (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .debug_mode (debug_mode),
        .debug_clk  (debug_clk),
        .resume     (resume),
        .halted     (halted),
        .pc         (pc),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .cpu_stb    (cpu_stb),
        .state      (state),
        .bp_hit     (bp_hit),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cpu-side PC model: advances one per strobe.
    always @(posedge clk) begin
        if (rst) pc <= '0;
        else if (cpu_stb) pc <= pc + 16'd1;
    end

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, act, act, exp, exp, cyc);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_stb(input int unsigned c);
        exp_t e;
        e.cyc = c;
        e.cnt = exp_cnt;
        sb.push_back(e);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    // Strobe monitor: every observed strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (cpu_stb) begin
            if (sb.size() == 0) begin
                check("stb_unexpected_cycle", cyc, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("stb_cycle", cyc, e.cyc);
                check("stb_count", instr_count, e.cnt);
            end
        end
    end

    initial begin
        // Reset state
        cycles(3);
        check("rst_state", state, 0);
        check("rst_stb", cpu_stb, 0);
        check("rst_count", instr_count, 0);
        check("rst_bp_hit", bp_hit, 0);

        // Free run: strobes on cycles 4, 8, 12 after release
        rst = 1'b0;
        r = cyc;
        exp_cnt = '0;
        push_stb(r + 4);
        push_stb(r + 8);
        push_stb(r + 12);
        cycles(12);
        debug_mode = 1'b1;
        cycles(1);
        check("run_count3", instr_count, 3);
        check("step_state", state, 1);

        // Single step: 3 pulses, strobe 3 cycles after each sampled rise
        for (int p = 0; p < 3; p++) begin
            debug_clk = 1'b1;
            push_stb(cyc + 4);
            cycles(5);
            debug_clk = 1'b0;
            cycles(5);
        end
        cycles(2);
        check("step_count6", instr_count, 6);
        check("step_state_hold", state, 1);

        // Breakpoint at PC 5
        rst = 1'b1;
        debug_mode = 1'b0;
        cycles(2);
        rst = 1'b0;
        bp_en = 1'b1;
        bp_addr = 16'h0005;
        r = cyc;
        exp_cnt = '0;
        for (int k = 1; k <= 5; k++) push_stb(r + 4 * k);
        cycles(30);
        check("bp_state", state, 2);
        check("bp_hit", bp_hit, 1);
        check("bp_pc", pc, 5);
        check("bp_count", instr_count, 5);

        // Resume: first strobe 4 cycles after resume is sampled, no re-break
        resume = 1'b1;
        s = cyc;
        push_stb(s + 5);
        push_stb(s + 9);
        cycles(1);
        resume = 1'b0;
        cycles(9);
        check("resume_state", state, 0);
        check("resume_pc", pc, 7);
        check("resume_bp_hit", bp_hit, 0);

        // Halt freezes; other debug inputs ignored
        halted = 1'b1;
        cycles(2);
        check("halt_state", state, 3);
        for (int i = 0; i < 50; i++) begin
            debug_mode = 1'($urandom);
            resume = 1'($urandom);
            debug_clk = 1'($urandom);
            cycles(1);
        end
        debug_mode = 1'b0;
        resume = 1'b0;
        debug_clk = 1'b0;
        cycles(2);
        check("halt_state_hold", state, 3);
        check("halt_count_hold", instr_count, 7);
        halted = 1'b0;
        rst = 1'b1;
        cycles(1);
        check("halt_rst_state", state, 0);
        check("halt_rst_count", instr_count, 0);
        check("halt_rst_stb", cpu_stb, 0);
        cycles(1);

        // Counter wrap from 16'hFFFE
        rst = 1'b0;
        r = cyc;
        cycles(1);
        force dut.instr_count = 16'hFFFE;
        cycles(1);
        release dut.instr_count;
        exp_cnt = 16'hFFFE;
        push_stb(r + 4);
        push_stb(r + 8);
        cycles(3);
        check("wrap_ffff", instr_count, 16'hFFFF);
        cycles(4);
        check("wrap_0000", instr_count, 0);

        // debug_clk held high through reset gives no step
        debug_clk = 1'b1;
        debug_mode = 1'b1;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        exp_cnt = '0;
        cycles(10);
        check("held_state", state, 1);
        check("held_no_step", instr_count, 0);
        debug_clk = 1'b0;
        cycles(5);
        debug_clk = 1'b1;
        push_stb(cyc + 4);
        cycles(5);
        check("held_then_step", instr_count, 1);

        // Reset in the middle of a step pulse discards it
        debug_clk = 1'b0;
        cycles(5);
        debug_clk = 1'b1;
        cycles(1);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        exp_cnt = '0;
        cycles(10);
        check("midrst_count", instr_count, 0);
        check("midrst_state", state, 1);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
